// File: rtl/control_loop_cmd_initiator_pkg.sv
// Shared control-loop command codes plus the state type of the command initiator.
package control_loop_cmd_initiator_pkg;

    localparam int unsigned CMD_WID = 8;

    localparam logic [CMD_WID-1:0] CMD_NOOP   = 8'h00;
    localparam logic [CMD_WID-1:0] CMD_STATUS = 8'h01;
    localparam logic [CMD_WID-1:0] CMD_SETPT  = 8'h02;
    localparam logic [CMD_WID-1:0] CMD_P      = 8'h03;
    localparam logic [CMD_WID-1:0] CMD_I      = 8'h04;
    localparam logic [CMD_WID-1:0] CMD_DELAY  = 8'h05;
    localparam logic [CMD_WID-1:0] CMD_ERR    = 8'h06;
    localparam logic [CMD_WID-1:0] CMD_Z      = 8'h07;
    localparam logic [CMD_WID-1:0] CMD_CYCLES = 8'h08;
    localparam logic [CMD_WID-1:0] WRITE_BIT  = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_WAIT_RELEASE
    } init_state_t;

endpackage

// File: rtl/control_loop_cmd_initiator.sv
// Initiator for the control loop's four-phase start_cmd/finish_cmd command handshake,
// with a per-phase timeout that turns a stuck command into an error response.
module control_loop_cmd_initiator
    import control_loop_cmd_initiator_pkg::*;
#(
    parameter int unsigned CMD_WID     = 8,
    parameter int unsigned DATA_WID    = 64,
    parameter int unsigned TIMEOUT     = 1000000,
    parameter int unsigned TIMEOUT_WID = 20
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CMD_WID-1:0]  req_cmd,
    input  logic [DATA_WID-1:0] req_data,

    output logic                resp_valid,
    output logic [DATA_WID-1:0] resp_data,
    output logic                resp_err,

    output logic [CMD_WID-1:0]  cmd,
    output logic [DATA_WID-1:0] word_in,
    input  logic [DATA_WID-1:0] word_out,
    output logic                start_cmd,
    input  logic                finish_cmd
);

    localparam logic [TIMEOUT_WID-1:0] TIMER_LAST = TIMEOUT_WID'(TIMEOUT - 1);

    init_state_t            state;
    logic [TIMEOUT_WID-1:0] timer;

    assign req_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            start_cmd  <= 1'b0;
            cmd        <= '0;
            word_in    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            timer      <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A stale finish_cmd here is not guarded: WAIT_ACK will ack at once.
                    if (req_valid) begin
                        cmd       <= req_cmd;
                        word_in   <= req_data;
                        start_cmd <= 1'b1;
                        timer     <= '0;
                        state     <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (finish_cmd) begin
                        resp_data <= word_out;
                        resp_err  <= 1'b0;
                        start_cmd <= 1'b0;
                        timer     <= '0;
                        state     <= ST_WAIT_RELEASE;
                    end else if (timer == TIMER_LAST) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                        start_cmd <= 1'b0;
                        timer     <= '0;
                        state     <= ST_WAIT_RELEASE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_WAIT_RELEASE: begin
                    if (!finish_cmd) begin
                        resp_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (timer == TIMER_LAST) begin
                        resp_err   <= 1'b1;
                        resp_data  <= '0;
                        resp_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    start_cmd <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_loop_cmd_initiator.sv
// Scoreboard bench for control_loop_cmd_initiator against a behavioural control-loop responder stub.
module tb_control_loop_cmd_initiator;
    import control_loop_cmd_initiator_pkg::*;

    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [7:0]    req_cmd = '0;
    logic [DW-1:0] req_data = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic [7:0]    cmd;
    logic [DW-1:0] word_in;
    logic [DW-1:0] word_out = '0;
    logic          start_cmd;
    logic          finish_cmd = 1'b0;

    control_loop_cmd_initiator #(
        .CMD_WID    (8),
        .DATA_WID   (DW),
        .TIMEOUT    (16),
        .TIMEOUT_WID(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_data  (req_data),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .cmd       (cmd),
        .word_in   (word_in),
        .word_out  (word_out),
        .start_cmd (start_cmd),
        .finish_cmd(finish_cmd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] preload(input int unsigned code);
        return (code == int'(CMD_STATUS)) ? '0 : (64'hA5A5_0000_0000_0000 | 64'(code));
    endfunction

    // Responder stub: acks one cycle after start_cmd, never acks CYCLES,
    // and in hold mode keeps finish_cmd high 40 cycles after start_cmd falls.
    bit            stub_hold = 1'b0;
    bit [DW-1:0]   stub_regs [128];
    bit            stub_wr   [128];
    int            hold_cnt  = 0;

    always @(posedge clk) begin
        if (start_cmd && cmd != CMD_CYCLES) begin
            if (!finish_cmd) begin
                if (cmd[7]) begin
                    stub_regs[cmd[6:0]] <= word_in;
                    stub_wr[cmd[6:0]]   <= 1'b1;
                    word_out            <= ~word_in;
                end else begin
                    word_out <= stub_wr[cmd[6:0]] ? stub_regs[cmd[6:0]] : preload(int'(cmd[6:0]));
                end
            end
            finish_cmd <= 1'b1;
            hold_cnt   <= stub_hold ? 40 : 0;
        end else if (hold_cnt != 0) begin
            hold_cnt <= hold_cnt - 1;
        end else begin
            finish_cmd <= 1'b0;
        end
    end

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mdl_regs [128];
    bit            mdl_wr   [128];

    // Output monitor: scoreboard pops, handshake timing and cmd/word_in stability.
    int            run_len = 0, last_start_len = 0, fall_cnt = 0, last_gap = -1;
    logic          prev_start = 1'b0;
    logic [7:0]    prev_cmd = '0;
    logic [DW-1:0] prev_wi = '0;

    always @(negedge clk) begin
        if (start_cmd) begin
            if (prev_start) begin
                check_val("cmd_stable", 64'(cmd), 64'(prev_cmd));
                check_val("word_in_stable", word_in, prev_wi);
            end
            run_len++;
        end else if (prev_start) begin
            last_start_len = run_len;
            run_len  = 0;
            fall_cnt = 0;
        end else begin
            fall_cnt++;
        end
        prev_start = start_cmd;
        prev_cmd   = cmd;
        prev_wi    = word_in;

        if (resp_valid && !rst) begin
            last_gap = fall_cnt;
            if (sb.size() == 0) begin
                check_val("resp_unexpected", 64'(resp_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("resp_err", 64'(resp_err), 64'(e.err));
                check_val("resp_data", resp_data, e.data);
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic [DW-1:0] d, input bit keep_valid, input bit expect_b2b);
        int   n;
        exp_t e;
        int unsigned code;
        code      = int'(c[6:0]);
        req_cmd   = c;
        req_data  = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check_val("accept_timeout", 64'(req_ready), 64'(1));
            req_valid = 1'b0;
            return;
        end
        if (expect_b2b) check_val("b2b_accept_in_resp_cycle", 64'(resp_valid), 64'(1));
        if (c == CMD_CYCLES || stub_hold) begin
            e.err  = 1'b1;
            e.data = '0;
        end else if (c[7]) begin
            e.err  = 1'b0;
            e.data = ~d;
            mdl_regs[code] = d;
            mdl_wr[code]   = 1'b1;
        end else begin
            e.err  = 1'b0;
            e.data = mdl_wr[code] ? mdl_regs[code] : preload(code);
        end
        sb.push_back(e);
        @(negedge clk);
        if (!keep_valid) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_val("resp_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_start_cmd", 64'(start_cmd), 64'(0));
        check_val("rst_cmd", 64'(cmd), 64'(0));
        check_val("rst_word_in", word_in, '0);
        check_val("rst_resp_valid", 64'(resp_valid), 64'(0));
        check_val("rst_resp_data", resp_data, '0);
        check_val("rst_resp_err", 64'(resp_err), 64'(0));
        check_val("rst_req_ready", 64'(req_ready), 64'(1));
        rst = 1'b0;
        @(negedge clk);

        send(CMD_STATUS, '0, 1'b0, 1'b0);
        wait_idle();
        check_val("status_start_len", 64'(last_start_len), 64'(2));
        check_val("status_resp_gap", 64'(last_gap), 64'(2));

        send(CMD_SETPT | WRITE_BIT, 64'h1234, 1'b0, 1'b0);
        wait_idle();
        send(CMD_SETPT, '0, 1'b0, 1'b0);
        wait_idle();

        send(CMD_CYCLES, '0, 1'b0, 1'b0);
        wait_idle();
        check_val("cycles_start_len", 64'(last_start_len), 64'(16));
        check_val("cycles_resp_gap", 64'(last_gap), 64'(1));

        stub_hold = 1'b1;
        send(CMD_I, '0, 1'b0, 1'b0);
        wait_idle();
        check_val("hold_resp_gap", 64'(last_gap), 64'(16));
        stub_hold = 1'b0;
        n = 0;
        while (finish_cmd && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("hold_release", 64'(finish_cmd), 64'(0));
        send(CMD_DELAY, '0, 1'b0, 1'b0);
        wait_idle();

        send(CMD_CYCLES, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_start_cmd", 64'(start_cmd), 64'(0));
        check_val("midrst_req_ready", 64'(req_ready), 64'(1));
        check_val("midrst_resp_valid", 64'(resp_valid), 64'(0));
        repeat (20) @(negedge clk);
        send(CMD_P, '0, 1'b0, 1'b0);
        wait_idle();

        send(CMD_Z | WRITE_BIT, 64'hCAFE_F00D_0000_0042, 1'b1, 1'b0);
        send(CMD_Z, '0, 1'b1, 1'b1);
        send(CMD_ERR, '0, 1'b0, 1'b1);
        wait_idle();

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
